multdiv: RTL and testbench

MULTDIV -- requirements
Module: multdiv

---
 rtl/multdiv.sv | 153 +++++++++++++++
 tb/tb_multdiv.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv.sv
// Iterative 32-bit signed multiplier (radix-4 Booth, 16 steps) and divider
// (non-restoring on magnitudes, 32 steps) sharing one FSM and a registered result.
module multdiv (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_count;
    logic        w_start;
    logic        w_mult_last;
    logic        w_div_last;

    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [32:0] r_mplier;
    logic [63:0] w_pp;
    logic [32:0] w_prod_hi;

    logic [33:0] r_rem;
    logic [33:0] w_rem_shift;
    logic [33:0] w_rem_next;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic        r_neg;
    logic        r_div_zero;
    logic        r_div_ovf;

    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;

    assign w_start     = ctrl_MULT | ctrl_DIV;
    assign w_mult_last = (r_state == S_MULT) && (r_count == 6'd16);
    assign w_div_last  = (r_state == S_DIV) && (r_count == 6'd32);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // NOTE: default assignment first so no path leaves w_state_next unassigned
    // (which would infer a latch).
    always_comb begin
        w_state_next = r_state;
        if (ctrl_MULT)     w_state_next = S_MULT;
        else if (ctrl_DIV) w_state_next = S_DIV;
        else begin
            case (r_state)
                S_MULT:  if (w_mult_last) w_state_next = S_DONE;
                S_DIV:   if (w_div_last)  w_state_next = S_DONE;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == S_MULT) || (r_state == S_DIV);
    end

    // Booth digit from multiplier bits {2i+1, 2i, 2i-1}; multiplicand pre-shifted by 2i.
    always_comb begin
        w_pp = '0;
        case (r_mplier[2:0])
            3'b001, 3'b010: w_pp = r_mcand;
            3'b011:         w_pp = r_mcand << 1;
            3'b100:         w_pp = -(r_mcand << 1);
            3'b101, 3'b110: w_pp = -r_mcand;
            default:        w_pp = '0;
        endcase
    end

    assign w_prod_hi   = r_acc[63:31];
    assign w_rem_shift = {r_rem[32:0], r_quo[31]};
    assign w_rem_next  = r_rem[33] ? (w_rem_shift + {2'b00, r_dvsr})
                                   : (w_rem_shift - {2'b00, r_dvsr});

    // r_quo shifts dividend magnitude out the top while quotient bits enter below.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_result   <= '0;
            r_exc      <= 1'b0;
            r_rdy      <= 1'b0;
        end else if (w_start) begin
            r_count    <= '0;
            r_rdy      <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= {{32{data_operandA[31]}}, data_operandA};
            r_mplier   <= {data_operandB, 1'b0};
            r_rem      <= '0;
            r_quo      <= data_operandA[31] ? -data_operandA : data_operandA;
            r_dvsr     <= data_operandB[31] ? -data_operandB : data_operandB;
            r_neg      <= data_operandA[31] ^ data_operandB[31];
            r_div_zero <= (data_operandB == 32'h0);
            r_div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_MULT: begin
                    if (w_mult_last) begin
                        r_result <= r_acc[31:0];
                        r_exc    <= !((&w_prod_hi) || !(|w_prod_hi));
                        r_rdy    <= 1'b1;
                    end else begin
                        r_acc    <= r_acc + w_pp;
                        r_mcand  <= r_mcand << 2;
                        r_mplier <= {{2{r_mplier[32]}}, r_mplier[32:2]};
                        r_count  <= r_count + 6'd1;
                    end
                end
                S_DIV: begin
                    if (w_div_last) begin
                        r_result <= r_div_zero ? 32'h0 : (r_neg ? -r_quo : r_quo);
                        r_exc    <= r_div_zero | r_div_ovf;
                        r_rdy    <= 1'b1;
                    end else begin
                        r_rem   <= w_rem_next;
                        r_quo   <= {r_quo[30:0], ~w_rem_next[33]};
                        r_count <= r_count + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
endmodule

// File: tb/tb_multdiv.sv
// Directed and reference-model bench for multdiv: latency, results, exceptions,
// abort/restart, MULT priority and asynchronous reset behaviour.
module tb_multdiv;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    multdiv dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Called at a falling edge; mode 0=mult, 1=div, 2=both strobes. Returns at the
    // falling edge where RDY is seen, lat = rising edges after the start edge.
    task automatic run_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic exc, output int lat,
                          output logic busy_mid, output logic busy_rdy);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = (mode != 1);
        ctrl_DIV      = (mode != 0);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        busy_mid      = busy;
        lat           = 0;
        while (data_resultRDY !== 1'b1 && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        res      = data_result;
        exc      = data_exception;
        busy_rdy = busy;
    endtask

    function automatic void model(input int mode, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] pv;
        logic [32:0] hi;
        sa = $signed(a);
        sb = $signed(b);
        if (mode != 1) begin
            p  = sa * sb;
            pv = p;
            r  = pv[31:0];
            hi = pv[63:31];
            e  = !(hi == 33'h0 || hi == 33'h1_FFFF_FFFF);
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            p  = sa / sb;
            pv = p;
            r  = pv[31:0];
            e  = 1'b0;
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0;
            3:       return 32'h1;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({data_resultRDY, busy, data_exception, data_result} !== 35'h0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b exc=%b res=%h, expected all 0",
                     data_resultRDY, busy, data_exception, data_result);
        end
    endtask

    task automatic test_mult();
        logic [31:0] va[3] = '{32'h0000_0007, 32'h0001_0000, 32'h4000_0000};
        logic [31:0] vb[3] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'h0000_0002};
        logic [31:0] vr[3] = '{32'hFFFF_FFD6, 32'h0000_0000, 32'h8000_0000};
        logic        ve[3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] res;
        logic        exc, bm, br;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(0, va[i], vb[i], res, exc, lat, bm, br);
            checks++;
            if (lat !== 17) begin
                failures++;
                $display("FAIL mult_latency[%0d]: got %0d expected 17", i, lat);
            end
            checks++;
            if (res !== vr[i] || exc !== ve[i]) begin
                failures++;
                $display("FAIL mult_result[%0d]: got %h/%b expected %h/%b", i, res, exc, vr[i], ve[i]);
            end
            checks++;
            if (bm !== 1'b1 || br !== 1'b0) begin
                failures++;
                $display("FAIL mult_busy[%0d]: got mid=%b rdy=%b expected 1/0", i, bm, br);
            end
            @(negedge clock);
            checks++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== vr[i]) begin
                failures++;
                $display("FAIL mult_after[%0d]: got rdy=%b busy=%b res=%h expected 0/0/%h",
                         i, data_resultRDY, busy, data_result, vr[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] va[2] = '{32'hFFFF_FF9C, 32'h8000_0000};
        logic [31:0] vb[2] = '{32'h0000_0007, 32'hFFFF_FFFF};
        logic [31:0] vr[2] = '{32'hFFFF_FFF2, 32'h8000_0000};
        logic        ve[2] = '{1'b0, 1'b1};
        logic [31:0] res;
        logic        exc, bm, br;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            run_op(1, va[i], vb[i], res, exc, lat, bm, br);
            checks++;
            if (lat !== 33) begin
                failures++;
                $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat);
            end
            checks++;
            if (res !== vr[i] || exc !== ve[i]) begin
                failures++;
                $display("FAIL div_result[%0d]: got %h/%b expected %h/%b", i, res, exc, vr[i], ve[i]);
            end
            @(negedge clock);
            checks++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL div_after[%0d]: got rdy=%b busy=%b expected 0/0", i, data_resultRDY, busy);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] res;
        logic        exc, bm, br;
        int          lat;
        run_op(1, 32'd123, 32'd0, res, exc, lat, bm, br);
        checks++;
        if (lat !== 33 || res !== 32'h0 || exc !== 1'b1) begin
            failures++;
            $display("FAIL div_zero: got lat=%0d res=%h exc=%b expected 33/00000000/1", lat, res, exc);
        end
        @(negedge clock);
    endtask

    task automatic test_abort();
        logic [31:0] res;
        logic        exc, bm, br;
        int          lat;
        int          seen = 0;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) seen++;
        end
        run_op(0, 32'd3, 32'd4, res, exc, lat, bm, br);
        checks++;
        if (lat !== 17 || res !== 32'd12 || exc !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart: got lat=%0d res=%h exc=%b expected 17/0000000c/0", lat, res, exc);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_div_rdy: got %0d pulses expected 0", seen);
        end
    endtask

    task automatic test_both();
        logic [31:0] res;
        logic        exc, bm, br;
        int          lat;
        run_op(2, 32'd6, 32'hFFFF_FFF9, res, exc, lat, bm, br);
        checks++;
        if (lat !== 17 || res !== 32'hFFFF_FFD6 || exc !== 1'b0) begin
            failures++;
            $display("FAIL both_ctrl: got lat=%0d res=%h exc=%b expected 17/ffffffd6/0", lat, res, exc);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        exc, bm, br;
        int          lat;
        int          seen = 0;
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({data_resultRDY, busy, data_exception, data_result} !== 35'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got rdy=%b busy=%b exc=%b res=%h expected all 0",
                     data_resultRDY, busy, data_exception, data_result);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) seen++;
        end
        reset_n = 1'b1;
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_rdy: got %0d pulses expected 0", seen);
        end
        run_op(0, 32'd5, 32'd5, res, exc, lat, bm, br);
        checks++;
        if (lat !== 17 || res !== 32'd25 || exc !== 1'b0) begin
            failures++;
            $display("FAIL first_start_after_reset: got lat=%0d res=%h exc=%b expected 17/00000019/0",
                     lat, res, exc);
        end
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, er;
        logic        exc, ee, bm, br;
        int          lat, mode, elat;
        for (int i = 0; i < 400; i++) begin
            mode = (i < 200) ? 0 : 1;
            elat = (mode == 0) ? 17 : 33;
            a    = pick();
            b    = pick();
            model(mode, a, b, er, ee);
            run_op(mode, a, b, res, exc, lat, bm, br);
            checks++;
            if (lat !== elat || res !== er || exc !== ee) begin
                failures++;
                $display("FAIL random[%0d] mode=%0d a=%h b=%h: got lat=%0d res=%h exc=%b expected %0d/%h/%b",
                         i, mode, a, b, lat, res, exc, elat, er, ee);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        test_reset();
        reset_n = 1'b1;
        test_mult();
        test_div();
        test_div_zero();
        test_abort();
        test_both();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
